dmem_responder: RTL and testbench

- Data-memory responder at the far end of the core's M-stage load/store interface.
- The core drives the address (ALU result), store data and MemWrite/MemRead.
- The block stores words in an internal RAM and returns ReadData after a configurable number of wait states.
- It holds the pipeline with Stall_M until each access completes, and it rejects misaligned or out-of-range addresses.

---
 rtl/dmem_responder_if.sv | 20 ++
 rtl/dmem_responder.sv | 104 ++++++++++
 tb/tb_dmem_responder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// M-stage load/store bus between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ALUResult_M;
  logic [31:0] WriteData_M;
  logic [31:0] ReadData;
  logic        Stall_M;
  logic        AddrErr;

  modport master (
    output MemRead, MemWrite, ALUResult_M, WriteData_M,
    input  ReadData, Stall_M, AddrErr
  );

  modport slave (
    input  MemRead, MemWrite, ALUResult_M, WriteData_M,
    output ReadData, Stall_M, AddrErr
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM behind the M-stage bus, stalls the pipeline for
// WAIT_CYCLES per accepted access and flags misaligned or out-of-range addresses.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  dmem
);

  localparam int unsigned IW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(WAIT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [31:0]     data_q, data_d;
  logic            wr_q, wr_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     mem [DEPTH_WORDS];

  logic req, err, accept, access;

  assign req    = dmem.MemRead | dmem.MemWrite;
  assign err    = req & ((dmem.ALUResult_M[1:0] != 2'b00) |
                         ({2'b00, dmem.ALUResult_M[31:2]} >= DEPTH_WORDS));
  assign accept = (state_q == IDLE) & req & ~err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d   = dmem.ALUResult_M[IW+1:2];
          data_d  = dmem.WriteData_M;
          wr_d    = dmem.MemWrite;
          cnt_d   = CW'(WAIT_CYCLES - 1);
          state_d = (WAIT_CYCLES == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The _d copies already hold the inputs on a single-wait-state acceptance, so the
  // access always uses them on the edge that enters DONE.
  assign access = (state_d == DONE);

  always_comb begin
    rdata_d = rdata_q;
    if (access && !wr_d) rdata_d = mem[idx_d];
  end

  always_ff @(posedge clk) begin
    if (reset && access && wr_d) mem[idx_d] <= data_d;
  end

  always_comb begin
    dmem.Stall_M = 1'b0;
    dmem.AddrErr = 1'b0;
    unique case (state_q)
      IDLE: begin
        dmem.Stall_M = accept;
        dmem.AddrErr = err;
      end
      BUSY:    dmem.Stall_M = 1'b1;
      default: dmem.Stall_M = 1'b0;
    endcase
    if (!reset) dmem.Stall_M = 1'b0;
  end

  assign dmem.ReadData = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;

    logic clk = 1'b0;
    logic reset;

    dmem_responder_if a ();
    dmem_responder_if b ();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .dmem  (a)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .dmem  (b)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref_rdata;

    function automatic bit addr_ok(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && ((addr >> 2) < DEPTH);
    endfunction

    // One request on DUT A; inputs are scrambled during BUSY to prove they were latched.
    task automatic access_a(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] mid_data,
                            input string tag);
        int   stall;
        bit   done;
        bit   acc;
        bit   exp_err;
        int   exp_stall;
        int   idx;
        acc       = (rd | wr) && addr_ok(addr);
        exp_err   = (rd | wr) && !addr_ok(addr);
        exp_stall = acc ? 2 : 0;
        idx       = int'(addr >> 2);
        if (acc && wr)  ref_mem[idx] = data;
        else if (acc)   ref_rdata    = ref_mem[idx];

        @(negedge clk);
        a.MemRead = rd; a.MemWrite = wr; a.ALUResult_M = addr; a.WriteData_M = data;
        stall = 0; done = 0;
        for (int k = 0; k < 8; k++) begin
            #2;
            if (k == 0) begin
                vectors++;
                if (a.AddrErr !== exp_err) begin
                    errors++;
                    $display("FAIL %s addrerr: got %b expected %b", tag, a.AddrErr, exp_err);
                end
            end
            if (a.Stall_M !== 1'b1) begin
                done = 1;
                break;
            end
            stall++;
            if (k >= 1) begin
                a.WriteData_M = mid_data;
                a.ALUResult_M = $urandom();
            end
            @(negedge clk);
        end
        vectors++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: stall still high after %0d cycles", tag, stall);
        end else if (stall != exp_stall) begin
            errors++;
            $display("FAIL %s stall: got %0d cycles expected %0d", tag, stall, exp_stall);
        end
        vectors++;
        if (a.ReadData !== ref_rdata) begin
            errors++;
            $display("FAIL %s readdata: got %h expected %h", tag, a.ReadData, ref_rdata);
        end
        if (stall > 0) begin
            vectors++;
            if (a.AddrErr !== 1'b0) begin
                errors++;
                $display("FAIL %s addrerr_done: got %b expected 0", tag, a.AddrErr);
            end
        end
        a.MemRead = 1'b0; a.MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        a.MemRead = 0; a.MemWrite = 0; a.ALUResult_M = '0; a.WriteData_M = '0;
        b.MemRead = 0; b.MemWrite = 0; b.ALUResult_M = '0; b.WriteData_M = '0;
        ref_rdata = '0;
        #12;
        vectors += 4;
        if (a.Stall_M !== 1'b0 || b.Stall_M !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b/%b expected 0/0", a.Stall_M, b.Stall_M);
        end
        if (a.ReadData !== 32'h0) begin
            errors++;
            $display("FAIL reset_readdata_a: got %h expected 00000000", a.ReadData);
        end
        if (b.ReadData !== 32'h0) begin
            errors++;
            $display("FAIL reset_readdata_b: got %h expected 00000000", b.ReadData);
        end
        if (a.AddrErr !== 1'b0 || b.AddrErr !== 1'b0) begin
            errors++;
            $display("FAIL reset_addrerr: got %b/%b expected 0/0", a.AddrErr, b.AddrErr);
        end
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic test_preload();
        for (int i = 0; i < int'(DEPTH); i++)
            access_a(1'b0, 1'b1, 32'(i) << 2, $urandom(), $urandom(), "preload");
    endtask

    task automatic test_store_load();
        access_a(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, $urandom(), "store_10");
        access_a(1'b1, 1'b0, 32'h10, $urandom(), $urandom(), "load_10");
        vectors++;
        if (a.ReadData !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_10_const: got %h expected deadbeef", a.ReadData);
        end
    endtask

    task automatic test_misaligned();
        access_a(1'b1, 1'b0, 32'h13, $urandom(), $urandom(), "misalign_ld");
        access_a(1'b0, 1'b1, 32'h22, $urandom(), $urandom(), "misalign_st");
        access_a(1'b1, 1'b0, 32'h20, $urandom(), $urandom(), "after_misalign");
    endtask

    task automatic test_out_of_range();
        access_a(1'b0, 1'b1, 32'h400, 32'hBAD0BAD0, $urandom(), "oor_st");
        access_a(1'b0, 1'b1, 32'h8000_0000, 32'hBAD1BAD1, $urandom(), "oor_hi_st");
        access_a(1'b1, 1'b0, 32'h0, $urandom(), $urandom(), "oor_ld0");
        access_a(1'b1, 1'b0, 32'h3FC, $urandom(), $urandom(), "top_word_ld");
    endtask

    task automatic test_simultaneous();
        access_a(1'b1, 1'b1, 32'h20, 32'h12345678, 32'h0, "both_ops");
        access_a(1'b1, 1'b0, 32'h20, $urandom(), $urandom(), "both_ops_ld");
        vectors++;
        if (a.ReadData !== 32'h12345678) begin
            errors++;
            $display("FAIL both_ops_word8: got %h expected 12345678", a.ReadData);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a.MemWrite = 1'b1; a.ALUResult_M = 32'h40; a.WriteData_M = 32'hAAAA5555;
        @(posedge clk);
        #1;
        vectors++;
        if (a.Stall_M !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_busy: stall got %b expected 1", a.Stall_M);
        end
        #2 reset = 1'b0;
        #1;
        vectors += 2;
        if (a.Stall_M !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_stall: got %b expected 0", a.Stall_M);
        end
        if (a.ReadData !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_readdata: got %h expected 00000000", a.ReadData);
        end
        ref_rdata = '0;
        @(posedge clk);
        @(negedge clk);
        a.MemWrite = 1'b0;
        #2 reset = 1'b1;
        access_a(1'b1, 1'b0, 32'h40, $urandom(), $urandom(), "rst_mid_ld");
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int unsigned kind, op;
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 9);
            op   = $urandom_range(0, 7);
            if (kind == 0)      addr = ($urandom_range(0, 255) << 2) | 32'($urandom_range(1, 3));
            else if (kind == 1) addr = ($urandom() | 32'h400) & ~32'h3;
            else                addr = $urandom_range(0, 15) << 2;
            access_a(op == 1 || (op >= 2 && op <= 4), op == 1 || op >= 5,
                     addr, $urandom(), $urandom(), "random");
        end
    endtask

    // DUT B has one wait state: requests held continuously give Stall 1,0,1,0,...
    task automatic test_back_to_back();
        logic [31:0] w [3];
        logic [31:0] ad [3];
        logic [31:0] exp_rd;
        int base;
        base = int'($urandom_range(0, 80)) * 3;
        for (int j = 0; j < 3; j++) begin
            w[j]  = $urandom();
            ad[j] = 32'(base + j) << 2;
        end
        exp_rd = b.ReadData === 32'h0 ? 32'h0 : 32'hFFFF_FFFF;
        for (int pass = 0; pass < 2; pass++) begin
            for (int j = 0; j < 3; j++) begin
                int jj;
                jj = (pass == 0) ? j : (j + 1) % 3;
                @(negedge clk);
                b.MemWrite = (pass == 0); b.MemRead = (pass == 1);
                b.ALUResult_M = ad[jj]; b.WriteData_M = w[jj];
                #2;
                vectors++;
                if (b.Stall_M !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_stall_idle p%0d j%0d: got %b expected 1", pass, j, b.Stall_M);
                end
                @(negedge clk);
                #2;
                if (pass == 1) exp_rd = w[jj];
                vectors += 2;
                if (b.Stall_M !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_stall_done p%0d j%0d: got %b expected 0", pass, j, b.Stall_M);
                end
                if (b.ReadData !== exp_rd) begin
                    errors++;
                    $display("FAIL b2b_readdata p%0d j%0d: got %h expected %h", pass, j, b.ReadData, exp_rd);
                end
            end
            b.MemWrite = 1'b0; b.MemRead = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_store_load();
        test_misaligned();
        test_out_of_range();
        test_simultaneous();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
